// File: rtl/resp_return.sv
// Return-path response steering for one crossbar master channel: tracks each accepted
// request's slave in order and forwards only the oldest slave's response; unmatched requests get a bus error.

// In-order tracking FIFO; head readable combinationally the cycle after a write.
module resp_return_fifo #(
    parameter int W       = 4,
    parameter int LGDEPTH = 3
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_wr,
    input  logic [W-1:0]       i_wdata,
    input  logic               i_rd,
    output logic [W-1:0]       o_rdata,
    output logic [LGDEPTH:0]   o_count,
    output logic               o_full,
    output logic               o_empty
);
    localparam int              DEPTH = 1 << LGDEPTH;
    localparam logic [LGDEPTH:0] FULL_CNT = {1'b1, {LGDEPTH{1'b0}}};

    logic [W-1:0]         r_mem [DEPTH];
    logic [LGDEPTH-1:0]   r_wptr;
    logic [LGDEPTH-1:0]   r_rptr;
    logic [LGDEPTH:0]     r_count;
    logic                 w_wr;
    logic                 w_rd;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];

    // Full blocks writes even when a read frees a slot in the same cycle.
    assign w_wr = i_wr && !o_full;
    assign w_rd = i_rd && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + LGDEPTH'(1);
            end
            if (w_rd) begin
                r_rptr <= r_rptr + LGDEPTH'(1);
            end
            if (w_wr && !w_rd) begin
                r_count <= r_count + (LGDEPTH+1)'(1);
            end else if (!w_wr && w_rd) begin
                r_count <= r_count - (LGDEPTH+1)'(1);
            end
        end
    end
endmodule

// Response steering: one registered stage, one response per cycle, head slave stalled while the master stalls.
module resp_return #(
    parameter int  NS           = 8,
    parameter int  DW           = 32,
    parameter int  LGDEPTH      = 3,
    parameter bit  OPT_LOWPOWER = 1'b0,
    localparam int LGNS         = $clog2(NS+1)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_req_valid,
    output logic                 o_req_stall,
    input  logic [NS:0]          i_req_decode,
    input  logic [NS-1:0]        i_slv_valid,
    output logic [NS-1:0]        o_slv_stall,
    input  logic [NS-1:0]        i_slv_err,
    input  logic [NS*DW-1:0]     i_slv_data,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_stall,
    output logic                 o_rsp_err,
    output logic [DW-1:0]        o_rsp_data,
    output logic [LGNS-1:0]      o_rsp_id,
    output logic [LGDEPTH:0]     o_outstanding,
    output logic                 o_fault
);
    localparam logic [LGNS-1:0] NS_IDX = LGNS'(NS);

    logic                 r_rsp_valid;
    logic                 r_rsp_err;
    logic [DW-1:0]        r_rsp_data;
    logic [LGNS-1:0]      r_rsp_id;
    logic                 r_fault;

    logic [LGNS-1:0]      w_push_idx;
    logic [LGNS-1:0]      w_head;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_ready;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_head_ns;
    logic                 w_head_valid;
    logic                 w_head_err;
    logic [DW-1:0]        w_head_data;

    // One-hot to index; with exactly one bit set the OR of indices is that index.
    always_comb begin
        w_push_idx = '0;
        for (int k = 0; k <= NS; k++) begin
            if (i_req_decode[k]) begin
                w_push_idx = w_push_idx | LGNS'(k);
            end
        end
    end

    assign w_push = i_req_valid && !w_full && (i_req_decode != '0);

    resp_return_fifo #(
        .W       (LGNS),
        .LGDEPTH (LGDEPTH)
    ) u_trk (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_wr    (w_push),
        .i_wdata (w_push_idx),
        .i_rd    (w_pop),
        .o_rdata (w_head),
        .o_count (o_outstanding),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign o_req_stall = w_full;
    assign w_ready     = !r_rsp_valid || !i_rsp_stall;
    assign w_head_ns   = (w_head == NS_IDX);

    always_comb begin
        w_head_valid = 1'b0;
        w_head_err   = 1'b0;
        w_head_data  = '0;
        for (int k = 0; k < NS; k++) begin
            if (w_head == LGNS'(k)) begin
                w_head_valid = i_slv_valid[k];
                w_head_err   = i_slv_err[k];
                w_head_data  = i_slv_data[k*DW +: DW];
            end
        end
    end

    // Only the head slave may ever see its stall drop; everyone else waits their turn.
    always_comb begin
        o_slv_stall = '1;
        for (int k = 0; k < NS; k++) begin
            if (!w_empty && (w_head == LGNS'(k))) begin
                o_slv_stall[k] = !w_ready;
            end
        end
    end

    assign w_pop = !w_empty && w_ready && (w_head_ns || w_head_valid);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
        end else if (w_ready) begin
            if (w_pop) begin
                r_rsp_valid <= 1'b1;
                r_rsp_id    <= w_head;
                if (w_head_ns) begin
                    r_rsp_err  <= 1'b1;
                    r_rsp_data <= '0;
                end else begin
                    r_rsp_err  <= w_head_err;
                    r_rsp_data <= w_head_data;
                end
            end else begin
                r_rsp_valid <= 1'b0;
                if (OPT_LOWPOWER) begin
                    r_rsp_err  <= 1'b0;
                    r_rsp_data <= '0;
                    r_rsp_id   <= '0;
                end
            end
        end
    end

    // A slave answering with nothing outstanding is a protocol violation; latch it for software.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_fault <= 1'b0;
        end else if (w_empty && (|i_slv_valid)) begin
            r_fault <= 1'b1;
        end
    end

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_err   = r_rsp_err;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_id    = r_rsp_id;
    assign o_fault     = r_fault;
endmodule

// File: tb/tb_resp_return.sv
// Randomized scoreboard bench for resp_return: requests and slave responses from queues,
// expected master responses checked in order by an independent monitor.
module tb_resp_return;
    localparam int NS = 8;
    localparam int DW = 32;
    localparam int LGDEPTH = 3;
    localparam int LGNS = 4;
    localparam int DEPTH = 8;

    logic               i_clk = 1'b0;
    logic               i_reset = 1'b1;
    logic               i_req_valid = 1'b0;
    logic               o_req_stall;
    logic [NS:0]        i_req_decode = '0;
    logic [NS-1:0]      i_slv_valid = '0;
    logic [NS-1:0]      o_slv_stall;
    logic [NS-1:0]      i_slv_err = '0;
    logic [NS*DW-1:0]   i_slv_data = '0;
    logic               o_rsp_valid;
    logic               i_rsp_stall = 1'b0;
    logic               o_rsp_err;
    logic [DW-1:0]      o_rsp_data;
    logic [LGNS-1:0]    o_rsp_id;
    logic [LGDEPTH:0]   o_outstanding;
    logic               o_fault;

    resp_return #(.NS(NS), .DW(DW), .LGDEPTH(LGDEPTH), .OPT_LOWPOWER(1'b0)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_req_valid(i_req_valid), .o_req_stall(o_req_stall),
        .i_req_decode(i_req_decode), .i_slv_valid(i_slv_valid), .o_slv_stall(o_slv_stall),
        .i_slv_err(i_slv_err), .i_slv_data(i_slv_data), .o_rsp_valid(o_rsp_valid),
        .i_rsp_stall(i_rsp_stall), .o_rsp_err(o_rsp_err), .o_rsp_data(o_rsp_data),
        .o_rsp_id(o_rsp_id), .o_outstanding(o_outstanding), .o_fault(o_fault)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int           id;
        logic [DW-1:0] d;
        logic         e;
    } rec_t;

    rec_t req_q[$];     // requests waiting to be presented
    rec_t pend[$];      // slave responses still owed
    rec_t exp_q[$];     // scoreboard of expected master responses
    int   trk[$];       // slave index of every request not yet answered, oldest first

    int errors = 0;
    int checks = 0;
    bit mon_en = 0;
    bit load_pending = 0;
    bit exp_fault = 0;
    bit rand_mode = 0;
    bit force_stall = 0;
    bit spur0 = 0;
    logic [NS-1:0] slv_en = '1;
    int slv_pct = 100;
    int stall_pct = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic int find_pend(input int k);
        for (int i = 0; i < pend.size(); i++) begin
            if (pend[i].id == k) return i;
        end
        return -1;
    endfunction

    function automatic logic [NS:0] decode_of(input int id);
        logic [NS:0] v;
        v = '0;
        if (id >= 0) v[id] = 1'b1;
        return v;
    endfunction

    // Observes the handshakes of the cycle just ending and updates the reference model.
    task automatic record();
        rec_t r;
        rec_t e;
        bit   rdy;
        int   h;
        int   idx;
        if (i_reset) begin
            req_q.delete(); pend.delete(); exp_q.delete(); trk.delete();
            exp_fault = 0;
            load_pending = 0;
            return;
        end
        if (trk.size() == 0 && (|i_slv_valid)) exp_fault = 1;
        rdy = !(o_rsp_valid && i_rsp_stall);
        load_pending = 0;
        if (trk.size() > 0) begin
            h = trk[0];
            if (h == NS) load_pending = rdy;
            else         load_pending = rdy && i_slv_valid[h];
        end
        for (int k = 0; k < NS; k++) begin
            if (i_slv_valid[k] && !o_slv_stall[k]) begin
                idx = find_pend(k);
                if (idx >= 0) pend.delete(idx);
            end
        end
        if (i_req_valid && !o_req_stall && req_q.size() > 0) begin
            r = req_q.pop_front();
            if (r.id >= 0) begin
                trk.push_back(r.id);
                if (r.id == NS) begin
                    e.id = NS; e.d = '0; e.e = 1'b1;
                    exp_q.push_back(e);
                end else begin
                    exp_q.push_back(r);
                    pend.push_back(r);
                end
            end
        end
    endtask

    task automatic drive();
        rec_t r;
        int   p;
        int   idx;
        if (rand_mode && req_q.size() == 0 && $urandom_range(99) < 45) begin
            p = $urandom_range(9);
            r.id = (p == 9) ? -1 : p;
            r.d  = $urandom;
            r.e  = ($urandom_range(7) == 0);
            req_q.push_back(r);
        end
        i_req_valid  = (req_q.size() > 0);
        i_req_decode = (req_q.size() > 0) ? decode_of(req_q[0].id) : (NS+1)'($urandom);
        for (int k = 0; k < NS; k++) begin
            i_slv_valid[k] = 1'b0;
            i_slv_err[k]   = 1'($urandom_range(1));
            i_slv_data[k*DW +: DW] = $urandom;
            idx = find_pend(k);
            if (idx >= 0 && slv_en[k] && $urandom_range(99) < slv_pct) begin
                i_slv_valid[k] = 1'b1;
                i_slv_err[k]   = pend[idx].e;
                i_slv_data[k*DW +: DW] = pend[idx].d;
            end
        end
        if (spur0) i_slv_valid[0] = 1'b1;
        i_rsp_stall = force_stall || ($urandom_range(99) < stall_pct);
    endtask

    initial begin
        forever begin
            @(negedge i_clk); #2;
            record();
            @(posedge i_clk); #1;
            drive();
        end
    end

    // Monitor: scoreboard pops, timing, flow control and bookkeeping outputs.
    initial begin
        bit            prev_v = 0, prev_s = 0, prev_rst = 0, new_txn, rdy;
        logic [DW-1:0] prev_d = '0;
        logic          prev_e = 1'b0;
        logic [LGNS-1:0] prev_id = '0;
        logic [NS-1:0] exp_ss;
        rec_t          e;
        forever begin
            @(negedge i_clk);
            if (mon_en) begin
                new_txn = o_rsp_valid && !(prev_v && prev_s);
                chk("load_timing", 64'(new_txn), 64'(load_pending));
                if (new_txn) begin
                    if (trk.size() > 0) void'(trk.pop_front());
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", 64'(o_rsp_valid), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_id",   64'(o_rsp_id),   64'(e.id));
                        chk("rsp_data", 64'(o_rsp_data), 64'(e.d));
                        chk("rsp_err",  64'(o_rsp_err),  64'(e.e));
                    end
                end else if (prev_v && prev_s && !prev_rst) begin
                    chk("hold_valid", 64'(o_rsp_valid), 64'(1));
                    chk("hold_data",  64'(o_rsp_data),  64'(prev_d));
                    chk("hold_id",    64'(o_rsp_id),    64'(prev_id));
                    chk("hold_err",   64'(o_rsp_err),   64'(prev_e));
                end
                chk("outstanding", 64'(o_outstanding), 64'(trk.size()));
                chk("req_stall",   64'(o_req_stall),   64'(trk.size() == DEPTH));
                chk("fault",       64'(o_fault),       64'(exp_fault));
                rdy = !(o_rsp_valid && i_rsp_stall);
                exp_ss = '1;
                if (trk.size() > 0 && trk[0] < NS) exp_ss[trk[0]] = !rdy;
                chk("slv_stall", 64'(o_slv_stall), 64'(exp_ss));
            end
            prev_v = o_rsp_valid; prev_s = i_rsp_stall; prev_rst = i_reset;
            prev_d = o_rsp_data; prev_e = o_rsp_err; prev_id = o_rsp_id;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge i_clk);
        #4;
    endtask

    task automatic push(input int id, input logic [DW-1:0] d, input logic e);
        rec_t r;
        r.id = id; r.d = d; r.e = e;
        req_q.push_back(r);
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || req_q.size() > 0 || trk.size() > 0) && n < maxc) begin
            cyc(1);
            n++;
        end
        chk("drain_timeout", 64'(exp_q.size() == 0 && req_q.size() == 0 && trk.size() == 0), 64'(1));
    endtask

    task automatic reset_pulse();
        @(posedge i_clk); #1;
        i_reset = 1'b1;
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        cyc(1);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_valid"}, 64'(o_rsp_valid), 64'(0));
        chk({tag, "_err"},   64'(o_rsp_err),   64'(0));
        chk({tag, "_data"},  64'(o_rsp_data),  64'(0));
        chk({tag, "_id"},    64'(o_rsp_id),    64'(0));
        chk({tag, "_cnt"},   64'(o_outstanding), 64'(0));
        chk({tag, "_fault"}, 64'(o_fault),     64'(0));
        chk({tag, "_rstall"}, 64'(o_req_stall), 64'(0));
        chk({tag, "_sstall"}, 64'(o_slv_stall), 64'(8'hFF));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge i_clk);
        #1 i_reset = 1'b0;
        cyc(1);
        reset_checks("reset");
        mon_en = 1;

        // Single response from slave 2.
        push(2, 32'hCAFE, 1'b0);
        drain(60);

        // Slave 3 ready first but must wait behind slave 1.
        slv_en = 8'h08;
        push(1, 32'h11, 1'b0);
        push(3, 32'h33, 1'b0);
        cyc(8);
        chk("order_hold_cnt", 64'(o_outstanding), 64'(2));
        slv_en = '1;
        drain(60);

        // No-slave request gets a local bus error.
        push(NS, 32'h0, 1'b0);
        drain(60);

        // Fill the tracker; the ninth request waits until a slot frees.
        slv_en = '0;
        for (int i = 0; i < 9; i++) push(i % NS, $urandom, 1'b0);
        cyc(15);
        chk("full_stall", 64'(o_req_stall), 64'(1));
        chk("full_cnt",   64'(o_outstanding), 64'(DEPTH));
        slv_en = '1;
        drain(100);

        // Master stall holds the output steady.
        force_stall = 1;
        push(5, 32'h55, 1'b1);
        push(6, 32'h66, 1'b0);
        cyc(4);
        chk("stall_valid", 64'(o_rsp_valid), 64'(1));
        cyc(5);
        force_stall = 0;
        drain(60);

        // Slave answering into an empty tracker raises a sticky fault.
        spur0 = 1;
        cyc(1);
        spur0 = 0;
        cyc(3);
        chk("fault_sticky", 64'(o_fault), 64'(1));
        reset_pulse();
        chk("fault_cleared", 64'(o_fault), 64'(0));

        // Randomized traffic with master backpressure.
        slv_pct = 60;
        stall_pct = 30;
        rand_mode = 1;
        cyc(1500);
        rand_mode = 0;
        drain(400);

        // Reset in the middle of traffic.
        rand_mode = 1;
        cyc(40);
        rand_mode = 0;
        reset_pulse();
        reset_checks("midreset");

        rand_mode = 1;
        cyc(300);
        rand_mode = 0;
        drain(400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
